// File: rtl/wave_sample_writer.sv
// Decimates, scales and clamps two 12-bit sample streams, then writes them into
// two circular display regions through one handshaked memory write port.
module wave_sample_writer #(
   parameter logic [11:0] BASE_A = 12'h559,
   parameter logic [11:0] BASE_B = 12'h6AD,
   parameter int          DEPTH  = 320,
   parameter int          DECIM  = 4,
   parameter int          SHIFT  = 4,
   parameter logic [7:0]  CLAMP  = 8'd90
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_a_valid,
   input  logic [11:0] i_a_data,
   input  logic        i_b_valid,
   input  logic [11:0] i_b_data,
   input  logic        i_freeze,
   output logic        o_mem_wen,
   output logic [11:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ready,
   output logic [8:0]  o_head_a,
   output logic [8:0]  o_head_b,
   output logic        o_overflow
);

   localparam int             CW        = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DECIM - 1);
   localparam logic [8:0]     HEAD_LAST = 9'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WR_A = 2'd1, WR_B = 2'd2} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          w_rr_toggle;
   logic          r_rr;
   logic [CW-1:0] r_cnt_a, r_cnt_b;
   logic          r_pend_a, r_pend_b;
   logic          r_newer_a, r_newer_b;
   logic [7:0]    r_hold_a, r_hold_b;
   logic [8:0]    r_head_a, r_head_b;
   logic          r_mem_wen;
   logic [11:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic          r_overflow;

   logic          w_acc_a, w_acc_b;
   logic          w_done_a, w_done_b;
   logic          w_launch_a, w_launch_b;
   logic [7:0]    w_code_a, w_code_b;

   function automatic logic [7:0] f_code(input logic [11:0] raw);
      logic [11:0] s;
      s = raw >> SHIFT;
      return (s > {4'b0000, CLAMP}) ? CLAMP : s[7:0];
   endfunction

   assign w_code_a   = f_code(i_a_data);
   assign w_code_b   = f_code(i_b_data);
   assign w_acc_a    = i_a_valid && (r_cnt_a == '0) && !i_freeze;
   assign w_acc_b    = i_b_valid && (r_cnt_b == '0) && !i_freeze;
   assign w_done_a   = (r_state == WR_A) && i_mem_ready;
   assign w_done_b   = (r_state == WR_B) && i_mem_ready;
   assign w_launch_a = (r_state == IDLE) && (w_state_next == WR_A);
   assign w_launch_b = (r_state == IDLE) && (w_state_next == WR_B);

   always_comb begin
      w_state_next = r_state;
      w_rr_toggle  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_pend_a && r_pend_b) begin
               w_state_next = r_rr ? WR_B : WR_A;
               w_rr_toggle  = 1'b1;
            end else if (r_pend_a) begin
               w_state_next = WR_A;
            end else if (r_pend_b) begin
               w_state_next = WR_B;
            end
         end
         WR_A, WR_B: begin
            if (i_mem_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_rr    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_rr_toggle) r_rr <= ~r_rr;
      end
   end

   // r_newer_x marks a sample that arrived after the in-flight write captured
   // hold_x, so completion must leave that channel pending.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt_a   <= '0;
         r_pend_a  <= 1'b0;
         r_newer_a <= 1'b0;
         r_hold_a  <= '0;
         r_head_a  <= '0;
      end else begin
         if (i_a_valid) r_cnt_a <= (r_cnt_a == CNT_LAST) ? '0 : r_cnt_a + 1'b1;
         if (w_done_a) begin
            r_head_a  <= (r_head_a == HEAD_LAST) ? '0 : r_head_a + 1'b1;
            r_pend_a  <= r_newer_a;
            r_newer_a <= 1'b0;
         end else if (w_launch_a) begin
            r_newer_a <= w_acc_a;
         end else if ((r_state == WR_A) && w_acc_a) begin
            r_newer_a <= 1'b1;
         end
         if (w_acc_a) begin
            r_pend_a <= 1'b1;
            r_hold_a <= w_code_a;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt_b   <= '0;
         r_pend_b  <= 1'b0;
         r_newer_b <= 1'b0;
         r_hold_b  <= '0;
         r_head_b  <= '0;
      end else begin
         if (i_b_valid) r_cnt_b <= (r_cnt_b == CNT_LAST) ? '0 : r_cnt_b + 1'b1;
         if (w_done_b) begin
            r_head_b  <= (r_head_b == HEAD_LAST) ? '0 : r_head_b + 1'b1;
            r_pend_b  <= r_newer_b;
            r_newer_b <= 1'b0;
         end else if (w_launch_b) begin
            r_newer_b <= w_acc_b;
         end else if ((r_state == WR_B) && w_acc_b) begin
            r_newer_b <= 1'b1;
         end
         if (w_acc_b) begin
            r_pend_b <= 1'b1;
            r_hold_b <= w_code_b;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_mem_wen   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_launch_a) begin
            r_mem_wen   <= 1'b1;
            r_mem_addr  <= BASE_A + {3'b000, r_head_a};
            r_mem_wdata <= {20'b0, r_hold_a, 4'b0};
         end else if (w_launch_b) begin
            r_mem_wen   <= 1'b1;
            r_mem_addr  <= BASE_B + {3'b000, r_head_b};
            r_mem_wdata <= {20'b0, r_hold_b, 4'b0};
         end else if (w_done_a || w_done_b) begin
            r_mem_wen <= 1'b0;
         end
         if ((w_acc_a && r_pend_a && !w_done_a) || (w_acc_b && r_pend_b && !w_done_b))
            r_overflow <= 1'b1;
      end
   end

   assign o_mem_wen   = r_mem_wen;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_head_a    = r_head_a;
   assign o_head_b    = r_head_b;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_wave_sample_writer.sv
// Bench for wave_sample_writer: directed scenarios plus a randomized run scored
// against a transaction-level model (per-channel queues of accepted codes).
module tb_wave_sample_writer;

   localparam logic [11:0] BASE_A = 12'h559;
   localparam logic [11:0] BASE_B = 12'h6AD;
   localparam int          DEPTH  = 320;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0, freeze = 1'b0, mem_ready = 1'b0;
   logic [11:0] a_data = '0, b_data = '0;

   logic        o1_wen, o4_wen, o1_ovf, o4_ovf;
   logic [11:0] o1_addr, o4_addr;
   logic [31:0] o1_wdata, o4_wdata;
   logic [8:0]  o1_head_a, o1_head_b, o4_head_a, o4_head_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wave_sample_writer #(.DECIM(1)) u_dut1 (
      .i_clock(clk), .i_reset(rst),
      .i_a_valid(a_valid), .i_a_data(a_data),
      .i_b_valid(b_valid), .i_b_data(b_data),
      .i_freeze(freeze),
      .o_mem_wen(o1_wen), .o_mem_addr(o1_addr), .o_mem_wdata(o1_wdata),
      .i_mem_ready(mem_ready),
      .o_head_a(o1_head_a), .o_head_b(o1_head_b), .o_overflow(o1_ovf)
   );

   wave_sample_writer #(.DECIM(4)) u_dut4 (
      .i_clock(clk), .i_reset(rst),
      .i_a_valid(a_valid), .i_a_data(a_data),
      .i_b_valid(b_valid), .i_b_data(b_data),
      .i_freeze(freeze),
      .o_mem_wen(o4_wen), .o_mem_addr(o4_addr), .o_mem_wdata(o4_wdata),
      .i_mem_ready(mem_ready),
      .o_head_a(o4_head_a), .o_head_b(o4_head_b), .o_overflow(o4_ovf)
   );

   // Expected memory word: integer divide by 16, saturate at 90, place at bit 4.
   function automatic logic [31:0] exp_word(input logic [11:0] raw);
      int s;
      s = int'(raw) / 16;
      if (s > 90) s = 90;
      return 32'(s * 16);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 0; b_valid = 0; freeze = 0; mem_ready = 0;
      a_data = '0; b_data = '0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      a_valid = 1; b_valid = 1; a_data = 12'h7FF; b_data = 12'h7FF; mem_ready = 1;
      repeat (3) cyc();
      n_checks++;
      if ({o1_wen, o1_addr, o1_wdata, o1_head_a, o1_head_b, o1_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut1 got wen=%0b addr=%h data=%h ha=%0d hb=%0d ovf=%0b want all 0",
                  o1_wen, o1_addr, o1_wdata, o1_head_a, o1_head_b, o1_ovf);
      end
      n_checks++;
      if ({o4_wen, o4_addr, o4_wdata, o4_head_a, o4_head_b, o4_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_dut4 got wen=%0b addr=%h data=%h want all 0", o4_wen, o4_addr, o4_wdata);
      end
      a_valid = 0; b_valid = 0;
      rst = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if (o1_wen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_pending got wen=%0b want 0", o1_wen);
      end
      $display("test_reset done");
   endtask

   task automatic test_first_write();
      do_reset();
      mem_ready = 1; a_valid = 1; a_data = 12'h3A0;
      cyc();
      a_valid = 0;
      n_checks++;
      if (o1_wen !== 1'b0) begin
         n_fail++; $display("FAIL first_early got wen=%0b want 0 after 1 edge", o1_wen);
      end
      cyc();
      n_checks++;
      if ({o1_wen, o1_addr, o1_wdata} !== {1'b1, 12'h559, 32'h000003A0}) begin
         n_fail++;
         $display("FAIL first_write got wen=%0b addr=%h data=%h want 1 559 000003a0", o1_wen, o1_addr, o1_wdata);
      end
      n_checks++;
      if ({o4_wen, o4_addr, o4_wdata} !== {1'b1, 12'h559, 32'h000003A0}) begin
         n_fail++;
         $display("FAIL first_write_d4 got wen=%0b addr=%h data=%h want 1 559 000003a0", o4_wen, o4_addr, o4_wdata);
      end
      cyc();
      n_checks++;
      if ({o1_wen, o1_head_a} !== {1'b0, 9'd1}) begin
         n_fail++; $display("FAIL first_head got wen=%0b head_a=%0d want 0 1", o1_wen, o1_head_a);
      end
      $display("test_first_write done");
   endtask

   task automatic test_clamp();
      logic        ch  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [11:0] raw [6] = '{12'hFFF, 12'h5A7, 12'h5B0, 12'h00F, 12'h123, 12'h59F};
      int ha, hb;
      logic [11:0] ea;
      ha = 1; hb = 0;
      for (int i = 0; i < 6; i++) begin
         if (ch[i]) begin b_valid = 1; b_data = raw[i]; end
         else       begin a_valid = 1; a_data = raw[i]; end
         cyc();
         a_valid = 0; b_valid = 0;
         cyc();
         ea = ch[i] ? BASE_B + 12'(hb) : BASE_A + 12'(ha);
         n_checks++;
         if ({o1_wen, o1_addr, o1_wdata} !== {1'b1, ea, exp_word(raw[i])}) begin
            n_fail++;
            $display("FAIL clamp_%0d got wen=%0b addr=%h data=%h want 1 %h %h",
                     i, o1_wen, o1_addr, o1_wdata, ea, exp_word(raw[i]));
         end
         if (ch[i]) hb++; else ha++;
         cyc();
      end
      n_checks++;
      if ({o1_head_a, o1_head_b} !== {9'(ha), 9'(hb)}) begin
         n_fail++; $display("FAIL clamp_heads got %0d %0d want %0d %0d", o1_head_a, o1_head_b, ha, hb);
      end
      $display("test_clamp done");
   endtask

   task automatic test_wrap();
      logic [11:0] d, ea;
      int bad;
      do_reset();
      mem_ready = 1;
      bad = 0;
      for (int i = 0; i <= DEPTH; i++) begin
         d = 12'($urandom);
         a_valid = 1; a_data = d;
         cyc();
         a_valid = 0;
         cyc();
         ea = BASE_A + 12'(i % DEPTH);
         n_checks++;
         if ({o1_wen, o1_addr, o1_wdata, o1_head_a} !== {1'b1, ea, exp_word(d), 9'(i % DEPTH)}) begin
            n_fail++; bad++;
            if (bad < 5)
               $display("FAIL wrap_%0d got wen=%0b addr=%h data=%h head=%0d want 1 %h %h %0d",
                        i, o1_wen, o1_addr, o1_wdata, o1_head_a, ea, exp_word(d), i % DEPTH);
         end
         if (i == DEPTH - 1) begin
            cyc();
            n_checks++;
            if ({o1_wen, o1_head_a} !== {1'b0, 9'd0}) begin
               n_fail++; $display("FAIL wrap_head got wen=%0b head=%0d want 0 0", o1_wen, o1_head_a);
            end
         end
      end
      cyc();
      n_checks++;
      if (o1_ovf !== 1'b0) begin
         n_fail++; $display("FAIL wrap_no_overflow got %0b want 0", o1_ovf);
      end
      $display("test_wrap done");
   endtask

   task automatic test_round_robin();
      logic [11:0] ra [4];
      logic [31:0] rd [4];
      logic [11:0] pa [2] = '{12'h100, 12'h310};
      logic [11:0] pb [2] = '{12'h200, 12'h420};
      logic [11:0] xa [2][2] = '{'{12'h559, 12'h6AD}, '{12'h6AE, 12'h55A}};
      logic [31:0] xd [2][2] = '{'{32'h100, 32'h200}, '{32'h420, 32'h310}};
      int n;
      do_reset();
      mem_ready = 1;
      for (int p = 0; p < 2; p++) begin
         a_valid = 1; b_valid = 1; a_data = pa[p]; b_data = pb[p];
         cyc();
         a_valid = 0; b_valid = 0;
         n = 0;
         for (int c = 0; c < 8; c++) begin
            if (o1_wen && mem_ready && n < 4) begin ra[n] = o1_addr; rd[n] = o1_wdata; n++; end
            cyc();
         end
         n_checks++;
         if (n != 2) begin
            n_fail++; $display("FAIL rr_count_%0d got %0d writes want 2", p, n);
         end else begin
            for (int k = 0; k < 2; k++) begin
               n_checks++;
               if ({ra[k], rd[k]} !== {xa[p][k], xd[p][k]}) begin
                  n_fail++;
                  $display("FAIL rr_order_%0d_%0d got %h %h want %h %h", p, k, ra[k], rd[k], xa[p][k], xd[p][k]);
               end
            end
         end
      end
      $display("test_round_robin done");
   endtask

   task automatic test_stall();
      int w;
      do_reset();
      mem_ready = 0; a_valid = 1; a_data = 12'h150;
      cyc();
      a_valid = 0;
      cyc();
      for (int s = 0; s < 10; s++) begin
         a_valid = (s == 2) || (s == 5);
         a_data  = (s == 2) ? 12'h200 : 12'h330;
         cyc();
         n_checks++;
         if ({o1_wen, o1_addr, o1_wdata} !== {1'b1, 12'h559, 32'h150}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got wen=%0b addr=%h data=%h want 1 559 00000150", s, o1_wen, o1_addr, o1_wdata);
         end
      end
      a_valid = 0;
      n_checks++;
      if (o1_ovf !== 1'b1) begin
         n_fail++; $display("FAIL stall_overflow got %0b want 1", o1_ovf);
      end
      mem_ready = 1;
      cyc();
      cyc();
      n_checks++;
      if ({o1_wen, o1_addr, o1_wdata, o1_head_a} !== {1'b1, 12'h55A, 32'h330, 9'd1}) begin
         n_fail++;
         $display("FAIL stall_latest got wen=%0b addr=%h data=%h head=%0d want 1 55a 00000330 1",
                  o1_wen, o1_addr, o1_wdata, o1_head_a);
      end
      cyc();
      w = 0;
      for (int c = 0; c < 4; c++) begin
         if (o1_wen) w++;
         cyc();
      end
      n_checks++;
      if (w != 0 || o1_head_a !== 9'd2) begin
         n_fail++; $display("FAIL stall_extra got %0d extra wen cycles head=%0d want 0 2", w, o1_head_a);
      end
      $display("test_stall done");
   endtask

   task automatic test_decim_freeze();
      logic [11:0] d [8];
      logic [11:0] ra [4];
      logic [31:0] rd [4];
      int n4, n1;
      do_reset();
      mem_ready = 1;
      n4 = 0;
      for (int c = 0; c < 14; c++) begin
         if (c < 8) begin d[c] = 12'($urandom); a_valid = 1; a_data = d[c]; end
         else a_valid = 0;
         if (o4_wen && mem_ready && n4 < 4) begin ra[n4] = o4_addr; rd[n4] = o4_wdata; n4++; end
         cyc();
      end
      n_checks++;
      if (n4 != 2) begin
         n_fail++; $display("FAIL decim_count got %0d writes want 2", n4);
      end else begin
         n_checks++;
         if ({ra[0], rd[0], ra[1], rd[1]} !== {12'h559, exp_word(d[0]), 12'h55A, exp_word(d[4])}) begin
            n_fail++;
            $display("FAIL decim_data got %h %h %h %h want 559 %h 55a %h", ra[0], rd[0], ra[1], rd[1],
                     exp_word(d[0]), exp_word(d[4]));
         end
      end
      freeze = 1;
      n4 = 0; n1 = 0;
      for (int c = 0; c < 14; c++) begin
         a_valid = (c < 8); a_data = 12'($urandom);
         if (o4_wen && mem_ready) n4++;
         if (o1_wen && mem_ready) n1++;
         cyc();
      end
      n_checks++;
      if (n4 != 0 || n1 != 0 || o4_head_a !== 9'd2) begin
         n_fail++; $display("FAIL freeze_hold got writes d4=%0d d1=%0d head=%0d want 0 0 2", n4, n1, o4_head_a);
      end
      freeze = 0;
      a_valid = 1; a_data = 12'h7F0;
      cyc();
      a_valid = 0;
      n4 = 0;
      for (int c = 0; c < 5; c++) begin
         if (o4_wen && mem_ready && n4 < 4) begin ra[n4] = o4_addr; rd[n4] = o4_wdata; n4++; end
         cyc();
      end
      n_checks++;
      if (n4 != 1 || ra[0] !== 12'h55B || rd[0] !== 32'h5A0 || o4_head_a !== 9'd3) begin
         n_fail++;
         $display("FAIL unfreeze got n=%0d addr=%h data=%h head=%0d want 1 55b 000005a0 3", n4, ra[0], rd[0], o4_head_a);
      end
      $display("test_decim_freeze done");
   endtask

   task automatic test_reset_mid_write();
      int w;
      do_reset();
      mem_ready = 0; a_valid = 1; a_data = 12'h3C0;
      cyc();
      a_valid = 0;
      cyc();
      n_checks++;
      if (o1_wen !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre got wen=%0b want 1", o1_wen);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({o1_wen, o1_addr, o1_wdata, o1_head_a, o1_ovf} !== '0) begin
         n_fail++; $display("FAIL midrst_async got wen=%0b addr=%h data=%h want all 0", o1_wen, o1_addr, o1_wdata);
      end
      cyc();
      rst = 1'b0; mem_ready = 1;
      w = 0;
      for (int c = 0; c < 4; c++) begin
         if (o1_wen) w++;
         cyc();
      end
      n_checks++;
      if (w != 0) begin
         n_fail++; $display("FAIL midrst_dropped got %0d wen cycles want 0", w);
      end
      $display("test_reset_mid_write done");
   endtask

   task automatic test_random();
      int qa[$], qb[$];
      int wa, wb, skip, ka, kb, j, code;
      logic done, p_wen;
      logic [11:0] p_addr, ea;
      logic [31:0] p_data;
      do_reset();
      wa = 0; wb = 0; skip = 0; ka = 0; kb = 0;
      for (int c = 0; c < 312; c++) begin
         if (c < 300) begin
            a_valid   = ($urandom_range(3) == 0) && (ka < 90);
            b_valid   = ($urandom_range(3) == 0) && (kb < 90);
            freeze    = ($urandom_range(7) == 0);
            mem_ready = ($urandom_range(1) == 0);
         end else begin
            a_valid = 0; b_valid = 0; freeze = 0; mem_ready = 1;
         end
         a_data = 12'($urandom); b_data = 12'($urandom);
         if (a_valid && !freeze) begin
            code   = (ka == 89) ? 90 : ka;
            a_data = (ka == 89) ? 12'($urandom_range(4095, 1440)) : 12'(ka * 16 + $urandom_range(15));
            qa.push_back(code); ka++;
         end
         if (b_valid && !freeze) begin
            code   = (kb == 89) ? 90 : kb;
            b_data = (kb == 89) ? 12'($urandom_range(4095, 1440)) : 12'(kb * 16 + $urandom_range(15));
            qb.push_back(code); kb++;
         end
         p_wen = o1_wen; p_addr = o1_addr; p_data = o1_wdata;
         done  = o1_wen && mem_ready;
         cyc();
         if (done) begin
            ea = (p_addr < BASE_B) ? BASE_A + 12'(wa % DEPTH) : BASE_B + 12'(wb % DEPTH);
            n_checks++;
            if (p_addr !== ea) begin
               n_fail++; $display("FAIL rand_addr cycle=%0d got %h want %h", c, p_addr, ea);
            end
            j = -1;
            if (p_addr < BASE_B) begin
               for (int k = 0; k < qa.size(); k++) if (j < 0 && 32'(qa[k] * 16) == p_data) j = k;
               if (j >= 0) begin skip += j; repeat (j + 1) void'(qa.pop_front()); end
               wa++;
            end else begin
               for (int k = 0; k < qb.size(); k++) if (j < 0 && 32'(qb[k] * 16) == p_data) j = k;
               if (j >= 0) begin skip += j; repeat (j + 1) void'(qb.pop_front()); end
               wb++;
            end
            n_checks++;
            if (j < 0) begin
               n_fail++; $display("FAIL rand_data cycle=%0d got %h which is no pending sample", c, p_data);
            end
         end else if (p_wen) begin
            n_checks++;
            if ({o1_wen, o1_addr, o1_wdata} !== {1'b1, p_addr, p_data}) begin
               n_fail++;
               $display("FAIL rand_stall cycle=%0d got %0b %h %h want 1 %h %h", c, o1_wen, o1_addr, o1_wdata, p_addr, p_data);
            end
         end
      end
      n_checks++;
      if (qa.size() != 0 || qb.size() != 0 || o1_wen !== 1'b0) begin
         n_fail++; $display("FAIL rand_drain got left a=%0d b=%0d wen=%0b want 0 0 0", qa.size(), qb.size(), o1_wen);
      end
      n_checks++;
      if ({o1_head_a, o1_head_b} !== {9'(wa % DEPTH), 9'(wb % DEPTH)}) begin
         n_fail++; $display("FAIL rand_heads got %0d %0d want %0d %0d", o1_head_a, o1_head_b, wa % DEPTH, wb % DEPTH);
      end
      if (skip > 0) begin
         n_checks++;
         if (o1_ovf !== 1'b1) begin
            n_fail++; $display("FAIL rand_overflow got %0b want 1 (%0d samples overwritten)", o1_ovf, skip);
         end
      end
      $display("test_random done writes a=%0d b=%0d overwritten=%0d", wa, wb, skip);
   endtask

   initial begin
      test_reset();
      test_first_write();
      test_clamp();
      test_wrap();
      test_round_robin();
      test_stall();
      test_decim_freeze();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
